// File: rtl/aryth_op_sequencer.sv
// Round-robin sequencer that shares one arithmetic datapath between two requesters,
// issuing through a start/done handshake and returning tagged results with a watchdog.
module aryth_op_sequencer #(
  parameter int WIDTH   = 8,
  parameter int OPW     = 3,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [OPW-1:0]     req0_op,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [OPW-1:0]     req1_op,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               alu_start,
  output logic [OPW-1:0]     alu_op,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  input  logic               alu_done,
  input  logic [2*WIDTH-1:0] alu_result,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_result,
  output logic               rsp_timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic               last_q, last_d;
  logic               id_q, id_d;
  logic [7:0]         timer_q, timer_d;
  logic [OPW-1:0]     op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               to_q, to_d;
  logic               grant;
  logic               accept;

  // On a tie the requester that did not win last time gets the grant.
  assign grant      = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  assign req0_ready = (state_q == IDLE) && req0_valid && !grant;
  assign req1_ready = (state_q == IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  assign alu_start   = (state_q == ISSUE);
  assign alu_op      = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_id      = id_q;
  assign rsp_result  = res_q;
  assign rsp_timeout = to_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    timer_d = timer_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    to_d    = to_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          id_d    = grant;
          last_d  = grant;
          op_d    = grant ? req1_op : req0_op;
          a_d     = grant ? req1_a  : req0_a;
          b_d     = grant ? req1_b  : req0_b;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = 8'd0;
        state_d = WAIT;
      end
      WAIT: begin
        // A done arriving on the expiry cycle still delivers the real result.
        if (alu_done) begin
          res_d   = alu_result;
          to_d    = 1'b0;
          state_d = RESP;
        end else if (timer_q == TLAST) begin
          res_d   = '0;
          to_d    = 1'b1;
          state_d = RESP;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      timer_q <= 8'd0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      timer_q <= timer_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      to_q    <= to_d;
    end
  end

endmodule
